// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pwm_pkg;

   // Alignment of the PWM period: sawtooth (edge) or triangle (center).
   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_t;

   // Full-scale duty value for a given counter width: 2^width - 1.
   function automatic int unsigned pwm_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: shadow duty, period-stable active duty, compare and output flop.
// Latency: dout follows the shared counter by one cycle; shadow writes reach dout at the next load.
// Backpressure: none, a write strobe is taken on every edge it is asserted.
//
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   wr_en_i       load wr_data_i into the shadow register
//   wr_data_i     new duty value
//   load_i        copy shadow into active (period boundary or while disabled)
//   en_i          run enable; output forced low when clear
//   cnt_i         shared period counter
//   dout_o        registered PWM output
module pwm_channel #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             dout_o
);

   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] active_q;
   logic             dout_q;
   logic             dout_d;

   // The compare uses the active value held during this cycle; a load on the
   // same edge only affects the following counter values.
   assign dout_d = en_i && (cnt_i < active_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         active_q <= '0;
         dout_q   <= 1'b0;
      end else begin
         if (wr_en_i) begin
            shadow_q <= wr_data_i;
         end
         // Active takes the pre-write shadow, so a write coincident with a
         // load is deferred to the next load.
         if (load_i) begin
            active_q <= shadow_q;
         end
         dout_q <= dout_d;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter feeding CHANNELS compare outputs.
// Latency: dout/period_start lag the counter by one cycle; a duty write shows within one period + 1.
// Backpressure: none, duty writes are accepted every cycle; out-of-range channels are dropped.
//
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   en            run enable; when low the counter parks at 0/up and outputs are low
//   mode          0 edge-aligned, 1 center-aligned; taken only at a period boundary
//   duty_wr       shadow duty write strobe
//   duty_ch       channel addressed by the write
//   duty_data     duty value to write
//   dout          registered PWM outputs, one per channel
//   period_start  registered one-cycle pulse per period
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic                duty_wr,
   input  logic [CHW-1:0]      duty_ch,
   input  logic [WIDTH-1:0]    duty_data,
   output logic [CHANNELS-1:0] dout,
   output logic                period_start
);

   // Last counter value before a wrap (edge) or a turn (center): M - 1.
   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(pwm_max(WIDTH) - 32'd1);
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   pwm_mode_t        mode_q, mode_d;
   logic             ps_q;
   logic             boundary;
   logic             load;
   pwm_mode_t        mode_eff;

   assign boundary = en && (cnt_q == '0) && (dir_q == DIR_UP);

   // While disabled the active registers follow the shadows every cycle, so
   // re-enabling starts a clean period with the latest values.
   assign load     = boundary || !en;
   assign mode_d   = load ? pwm_mode_t'(mode) : mode_q;

   // The step taken out of a boundary cycle already belongs to the new period.
   assign mode_eff = mode_d;

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!en) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (mode_eff == PWM_EDGE) begin
         dir_d = DIR_UP;
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      end else if (dir_q == DIR_UP) begin
         // Top value is held for one extra cycle while turning round.
         if (cnt_q == CNT_LAST) begin
            dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         // Zero is likewise held once on the way down; the up-side 0 is the boundary.
         if (cnt_q == '0) begin
            dir_d = DIR_UP;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         dir_q  <= DIR_UP;
         mode_q <= PWM_EDGE;
         ps_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         mode_q <= mode_d;
         ps_q   <= boundary;
      end
   end

   assign period_start = ps_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic wr_en;

      // Codes at or above CHANNELS match no instance, so those writes vanish.
      assign wr_en = duty_wr && (duty_ch == CHW'(i));

      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (wr_en),
         .wr_data_i (duty_data),
         .load_i    (load),
         .en_i      (en),
         .cnt_i     (cnt_q),
         .dout_o    (dout[i])
      );
   end

endmodule
